btb_update_ctrl: RTL and testbench

BTB_UPDATE_CTRL -- requirements
Module: btb_update_ctrl

---
 rtl/btb_update_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_btb_update_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/btb_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : btb_update_ctrl
// Description : Write-side controller for a 128-entry branch target buffer.
//               After reset it invalidates every entry with a sweep, then
//               accepts up to two predictor updates per cycle from a
//               dual-issue writeback stage into a 4-entry FIFO. It drains
//               that FIFO onto the BTB RAM write port at one entry per cycle.
//               A flush request discards queued updates and re-runs the
//               invalidate sweep.
//
// Ports       : clk, rst_n              - clock, synchronous active-low reset
//               u0_* / u1_*             - update lanes (lane 0 older):
//                                         valid, pc, target, alloc
//               upd_ready               - both lanes may be accepted this cycle
//               flush_req               - one-cycle pulse to clear the BTB
//               flush_busy              - init/flush sweep in progress
//               w_we, w_valid, w_addr,
//               w_tag, w_target         - registered BTB RAM write port
//
// Options     : BTB_UPD_MERGE_EN - when defined, two same-cycle updates to
//               the same BTB index collapse into the younger (lane 1) one.
//
// Revision    : 1.0 - initial release
// ============================================================================
module btb_update_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        u0_valid,
  input  logic [31:0] u0_pc,
  input  logic [31:0] u0_target,
  input  logic        u0_alloc,
  input  logic        u1_valid,
  input  logic [31:0] u1_pc,
  input  logic [31:0] u1_target,
  input  logic        u1_alloc,
  output logic        upd_ready,
  input  logic        flush_req,
  output logic        flush_busy,
  output logic        w_we,
  output logic        w_valid,
  output logic [6:0]  w_addr,
  output logic [21:0] w_tag,
  output logic [31:0] w_target
);

  localparam int unsigned C_FIFO_DEPTH = 4;
  localparam logic [6:0]  C_LAST_IDX   = 7'd127;
  localparam logic [2:0]  C_MAX_FILL   = 3'd2;  // room left for two pushes

  typedef enum logic [1:0] {
    INIT_SWEEP  = 2'd0,
    RUN         = 2'd1,
    FLUSH_SWEEP = 2'd2
  } state_e;

  // One queued BTB update, already split into RAM fields.
  typedef struct packed {
    logic        alloc;
    logic [6:0]  idx;
    logic [21:0] tag;
    logic [31:0] target;
  } entry_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e      state_q;
  logic [6:0]  sweep_cnt_q;

  entry_t      fifo_q [C_FIFO_DEPTH];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q,  count_d;

  logic        w_we_q;
  logic        w_valid_q;
  logic [6:0]  w_addr_q;
  logic [21:0] w_tag_q;
  logic [31:0] w_target_q;

  // --------------------------------------------------------------------------
  // Acceptance and FIFO control
  // --------------------------------------------------------------------------
  logic        w_run;
  logic        w_ready;
  logic        w_acc0, w_acc1;
  logic        w_merge;
  logic        w_push0, w_push1;
  logic        w_flush;
  logic        w_pop;
  logic [1:0]  w_slot1;
  entry_t      w_ent0, w_ent1, w_head;

  // PC bits [2:0] never reach the BTB (instruction-aligned branches).
  logic        w_unused_pc_lsbs;
  assign w_unused_pc_lsbs = ^{u0_pc[2:0], u1_pc[2:0]};

  assign w_run   = (state_q == RUN);
  // Ready only if both lanes fit even when nothing drains this cycle.
  assign w_ready = w_run && (count_q <= C_MAX_FILL);
  assign w_acc0  = u0_valid && w_ready;
  assign w_acc1  = u1_valid && w_ready;

`ifdef BTB_UPD_MERGE_EN
  // Same index in one cycle: the younger lane's update supersedes lane 0.
  assign w_merge = w_acc0 && w_acc1 && (u0_pc[9:3] == u1_pc[9:3]);
`else
  assign w_merge = 1'b0;
`endif

  assign w_push0 = w_acc0 && !w_merge;
  assign w_push1 = w_acc1;

  assign w_flush = w_run && flush_req;
  // A flush edge discards the queue, so the head is not written either.
  assign w_pop   = w_run && (count_q != 3'd0) && !w_flush;

  // Lane 1 lands behind lane 0 when both are pushed.
  assign w_slot1 = wr_ptr_q + {1'b0, w_push0};

  assign w_ent0 = '{alloc: u0_alloc, idx: u0_pc[9:3], tag: u0_pc[31:10], target: u0_target};
  assign w_ent1 = '{alloc: u1_alloc, idx: u1_pc[9:3], tag: u1_pc[31:10], target: u1_target};
  assign w_head = fifo_q[rd_ptr_q];

  always_comb begin
    count_d  = count_q + {2'b00, w_push0} + {2'b00, w_push1} - {2'b00, w_pop};
    wr_ptr_d = wr_ptr_q + {1'b0, w_push0} + {1'b0, w_push1};
    rd_ptr_d = rd_ptr_q + {1'b0, w_pop};
    if (!w_run || w_flush) begin
      count_d  = 3'd0;
      wr_ptr_d = 2'd0;
      rd_ptr_d = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q  <= 3'd0;
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      for (int i = 0; i < C_FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (w_push0) begin
        fifo_q[wr_ptr_q] <= w_ent0;
      end
      if (w_push1) begin
        fifo_q[w_slot1] <= w_ent1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM and registered write port
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= INIT_SWEEP;
      sweep_cnt_q <= 7'd0;
      w_we_q      <= 1'b0;
      w_valid_q   <= 1'b0;
      w_addr_q    <= 7'd0;
      w_tag_q     <= 22'd0;
      w_target_q  <= 32'd0;
    end else begin
      case (state_q)
        INIT_SWEEP, FLUSH_SWEEP: begin
          // Invalidate one entry per cycle; flush_req is ignored here.
          w_we_q      <= 1'b1;
          w_valid_q   <= 1'b0;
          w_addr_q    <= sweep_cnt_q;
          w_tag_q     <= 22'd0;
          w_target_q  <= 32'd0;
          sweep_cnt_q <= sweep_cnt_q + 7'd1;
          if (sweep_cnt_q == C_LAST_IDX) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (w_flush) begin
            state_q     <= FLUSH_SWEEP;
            sweep_cnt_q <= 7'd0;
            w_we_q      <= 1'b0;
          end else if (w_pop) begin
            w_we_q     <= 1'b1;
            w_valid_q  <= w_head.alloc;
            w_addr_q   <= w_head.idx;
            w_tag_q    <= w_head.tag;
            w_target_q <= w_head.target;
          end else begin
            // Data fields hold their last value while idle.
            w_we_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= INIT_SWEEP;
          sweep_cnt_q <= 7'd0;
          w_we_q      <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign upd_ready  = w_ready;
  assign flush_busy = !w_run;
  assign w_we       = w_we_q;
  assign w_valid    = w_valid_q;
  assign w_addr     = w_addr_q;
  assign w_tag      = w_tag_q;
  assign w_target   = w_target_q;

endmodule
`default_nettype wire

// File: tb/tb_btb_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_btb_update_ctrl
// Description : Directed, self-checking bench for btb_update_ctrl. A table of
//               per-cycle lane inputs and expected post-edge outputs covers
//               the RUN-state datapath; hand-written sequences cover the
//               reset sweep, flush with a loaded queue, flush_req during a
//               sweep, and reset in the middle of a sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btb_update_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        u0_valid, u1_valid;
  logic [31:0] u0_pc, u1_pc, u0_target, u1_target;
  logic        u0_alloc, u1_alloc;
  logic        upd_ready;
  logic        flush_req;
  logic        flush_busy;
  logic        w_we, w_valid;
  logic [6:0]  w_addr;
  logic [21:0] w_tag;
  logic [31:0] w_target;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  btb_update_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .u0_valid   (u0_valid),
    .u0_pc      (u0_pc),
    .u0_target  (u0_target),
    .u0_alloc   (u0_alloc),
    .u1_valid   (u1_valid),
    .u1_pc      (u1_pc),
    .u1_target  (u1_target),
    .u1_alloc   (u1_alloc),
    .upd_ready  (upd_ready),
    .flush_req  (flush_req),
    .flush_busy (flush_busy),
    .w_we       (w_we),
    .w_valid    (w_valid),
    .w_addr     (w_addr),
    .w_tag      (w_tag),
    .w_target   (w_target)
  );

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        a;
  } lane_t;

  typedef struct packed {
    logic        rdy;
    logic        busy;
    logic        we;
    logic        val;
    logic [6:0]  addr;
    logic [21:0] tag;
    logic [31:0] tgt;
  } out_t;

  typedef struct packed {
    lane_t l0;
    lane_t l1;
    out_t  e;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];

  function automatic lane_t L(input logic [31:0] pc, input logic [31:0] tgt, input logic a);
    L = '{v: 1'b1, pc: pc, tgt: tgt, a: a};
  endfunction

  function automatic out_t O(input logic rdy, input logic busy, input logic we, input logic val,
                             input logic [6:0] addr, input logic [21:0] tag, input logic [31:0] tgt);
    O = '{rdy: rdy, busy: busy, we: we, val: val, addr: addr, tag: tag, tgt: tgt};
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input lane_t a, input lane_t b);
    u0_valid  = a.v;  u0_pc = a.pc;  u0_target = a.tgt;  u0_alloc = a.a;
    u1_valid  = b.v;  u1_pc = b.pc;  u1_target = b.tgt;  u1_alloc = b.a;
  endtask

  function automatic logic [71:0] act_full();
    act_full = {6'd0, upd_ready, flush_busy, w_we, w_valid, w_addr, w_tag, w_target};
  endfunction

  function automatic logic [71:0] act_flags();
    act_flags = {69'd0, upd_ready, flush_busy, w_we};
  endfunction

  // n invalidate writes starting at index 0; optional flush_req pulse at
  // index pulse_at must not disturb the sweep.
  task automatic sweep_check(input string name, input int n, input int pulse_at);
    for (int i = 0; i < n; i++) begin
      flush_req = (i == pulse_at);
      tick();
      chk($sformatf("%s[%0d]", name, i), act_full(),
          {6'd0, (i == 127), (i != 127), 1'b1, 1'b0, 7'(i), 22'd0, 32'd0});
    end
    flush_req = 1'b0;
  endtask

  lane_t N;

  initial begin
    N = '0;
    // ---------------- vector table (RUN state, empty queue at start) -------
    tbl[0]  = '{L(32'h1C000408, 32'h1C000500, 1'b1), N, O(1,0,0,0,7'h00,22'h0,32'h0)};
    tbl[1]  = '{N, N, O(1,0,1,1,7'h01,22'h070001,32'h1C000500)};
    tbl[2]  = '{N, N, O(1,0,0,0,7'h00,22'h0,32'h0)};
    // three back-to-back dual updates; third pair arrives while not ready
    tbl[3]  = '{L(32'h00000C18, 32'h00001003, 1'b1), L(32'h00001020, 32'h00001004, 1'b0), O(1,0,0,0,7'h00,22'h0,32'h0)};
    tbl[4]  = '{L(32'h00001428, 32'h00001005, 1'b1), L(32'h00001830, 32'h00001006, 1'b0), O(0,0,1,1,7'h03,22'h3,32'h00001003)};
    tbl[5]  = '{L(32'h00001C38, 32'h00001007, 1'b1), L(32'h00002040, 32'h00001008, 1'b1), O(1,0,1,0,7'h04,22'h4,32'h00001004)};
    tbl[6]  = '{N, N, O(1,0,1,1,7'h05,22'h5,32'h00001005)};
    tbl[7]  = '{N, N, O(1,0,1,0,7'h06,22'h6,32'h00001006)};
    tbl[8]  = '{N, N, O(1,0,0,0,7'h00,22'h0,32'h0)};
    // same index (2) on both lanes in one cycle
    tbl[9]  = '{L(32'h00000010, 32'h20000010, 1'b1), L(32'h00000410, 32'h20000410, 1'b1), O(1,0,0,0,7'h00,22'h0,32'h0)};
`ifdef BTB_UPD_MERGE_EN
    tbl[10] = '{N, N, O(1,0,1,1,7'h02,22'h1,32'h20000410)};
    tbl[11] = '{N, N, O(1,0,0,0,7'h00,22'h0,32'h0)};
`else
    tbl[10] = '{N, N, O(1,0,1,1,7'h02,22'h0,32'h20000010)};
    tbl[11] = '{N, N, O(1,0,1,1,7'h02,22'h1,32'h20000410)};
`endif
    tbl[12] = '{N, N, O(1,0,0,0,7'h00,22'h0,32'h0)};
    // invalidate update, then lane-1-only update at the top index
    tbl[13] = '{L(32'h00000028, 32'hDEADBEEF, 1'b0), N, O(1,0,0,0,7'h00,22'h0,32'h0)};
    tbl[14] = '{N, N, O(1,0,1,0,7'h05,22'h0,32'hDEADBEEF)};
    tbl[15] = '{N, L(32'hFFFFFFF8, 32'h12345678, 1'b1), O(1,0,0,0,7'h00,22'h0,32'h0)};
    tbl[16] = '{N, N, O(1,0,1,1,7'h7F,22'h3FFFFF,32'h12345678)};
    tbl[17] = '{N, N, O(1,0,0,0,7'h00,22'h0,32'h0)};

    // ---------------- reset -------------------------------------------------
    rst_n = 1'b0;
    flush_req = 1'b0;
    drive(N, N);
    repeat (3) tick();
    chk("reset_state", act_full(), {6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 22'd0, 32'd0});

    // ---------------- initial sweep ----------------------------------------
    rst_n = 1'b1;
    sweep_check("init_sweep", 128, -1);

    // ---------------- table-driven RUN vectors -----------------------------
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].l0, tbl[i].l1);
      tick();
      if (tbl[i].e.we)
        chk($sformatf("vec%0d", i), act_full(), {6'd0, tbl[i].e});
      else
        chk($sformatf("vec%0d", i), act_flags(), {69'd0, tbl[i].e.rdy, tbl[i].e.busy, 1'b0});
    end

    // ---------------- flush with three queued entries ----------------------
    drive(L(32'h00002448, 32'h00003009, 1'b1), L(32'h00002850, 32'h0000300A, 1'b1));
    tick();
    chk("fl_load0", act_flags(), {69'd0, 1'b1, 1'b0, 1'b0});
    drive(L(32'h00002C58, 32'h0000300B, 1'b1), L(32'h00003060, 32'h0000300C, 1'b1));
    tick();
    chk("fl_load1", act_full(), {6'd0, 1'b0, 1'b0, 1'b1, 1'b1, 7'd9, 22'd9, 32'h00003009});
    drive(N, N);
    flush_req = 1'b1;
    tick();
    chk("fl_enter", act_flags(), {69'd0, 1'b0, 1'b1, 1'b0});
    // queued entries would show w_valid=1 / nonzero tag; sweep expects none
    sweep_check("flush_sweep", 128, 10);
    tick();
    chk("fl_idle", act_flags(), {69'd0, 1'b1, 1'b0, 1'b0});

    // ---------------- reset in the middle of a flush sweep -----------------
    flush_req = 1'b1;
    tick();
    chk("fl2_enter", act_flags(), {69'd0, 1'b0, 1'b1, 1'b0});
    sweep_check("flush2_part", 60, -1);
    rst_n = 1'b0;
    tick();
    chk("mid_reset", act_full(), {6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 22'd0, 32'd0});
    rst_n = 1'b1;
    sweep_check("restart_sweep", 128, -1);
    tick();
    chk("restart_idle", act_flags(), {69'd0, 1'b1, 1'b0, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
